// File: rtl/m_axis_cq_filter.sv
// rtl/m_axis_cq_filter.sv - CQ request filter: forwards memory requests, drops the rest, FIFO-buffered
//
// Purpose: classifies each legacy-format request TLP on its first beat.
//   Memory read/write TLPs are pushed into a small FIFO. All other TLPs are
//   accepted and discarded, and a saturating counter records them.
// Ports:
//   user_clk, user_reset          clock, async active-high reset
//   s_axis_t*                     request stream from the CQ adapter
//                                 (tready is 4 identical bits)
//   m_axis_t*                     filtered stream toward the depacketizer
//   drop_count, drop_pulse        dropped-TLP counter (saturating) and per-TLP pulse
module m_axis_cq_filter #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 4
) (
  input  logic                  user_clk,
  input  logic                  user_reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic [84:0]           s_axis_tuser,
  input  logic                  s_axis_tvalid,
  output logic [3:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [84:0]           m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [15:0]           drop_count,
  output logic                  drop_pulse
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_SOP, ST_PASS, ST_DROP} state_t;

  state_t          state;
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW:0]     occupancy;
  logic            full;
  logic            empty;
  logic            in_xfer;
  logic            out_xfer;
  logic            is_pass;
  logic            push;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [KEEP_WIDTH-1:0] mem_keep [DEPTH];
  logic                  mem_last [DEPTH];
  logic [84:0]           mem_user [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign occupancy = wr_ptr - rd_ptr;
  assign full      = (occupancy == (AW+1)'(DEPTH));
  assign empty     = (wr_ptr == rd_ptr);

  // While discarding, the FIFO is not touched, so backpressure is never needed.
  assign s_axis_tready = (state == ST_DROP) ? 4'hF : {4{~full}};

  assign in_xfer  = s_axis_tvalid & s_axis_tready[0];
  assign out_xfer = m_axis_tvalid & m_axis_tready;

  // Memory read/write: type 0 with a 3/4-DW, with/without-data format (fmt[2] clear).
  assign is_pass = (s_axis_tdata[28:24] == 5'b00000) && (s_axis_tdata[31] == 1'b0);

  assign push = in_xfer & (((state == ST_SOP) & is_pass) | (state == ST_PASS));

  assign m_axis_tvalid = ~empty;
  assign m_axis_tdata  = mem_data[rd_ptr[AW-1:0]];
  assign m_axis_tkeep  = mem_keep[rd_ptr[AW-1:0]];
  assign m_axis_tlast  = mem_last[rd_ptr[AW-1:0]];
  assign m_axis_tuser  = mem_user[rd_ptr[AW-1:0]];

  // FIFO storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge user_clk) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= s_axis_tdata;
      mem_keep[wr_ptr[AW-1:0]] <= s_axis_tkeep;
      mem_last[wr_ptr[AW-1:0]] <= s_axis_tlast;
      mem_user[wr_ptr[AW-1:0]] <= s_axis_tuser;
    end
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state      <= ST_SOP;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drop_count <= 16'h0000;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (out_xfer) rd_ptr <= rd_ptr + 1'b1;
      if (in_xfer) begin
        case (state)
          ST_SOP: begin
            if (is_pass) begin
              state <= s_axis_tlast ? ST_SOP : ST_PASS;
            end else begin
              drop_pulse <= 1'b1;
              if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
              state <= s_axis_tlast ? ST_SOP : ST_DROP;
            end
          end
          ST_PASS: if (s_axis_tlast) state <= ST_SOP;
          ST_DROP: if (s_axis_tlast) state <= ST_SOP;
          default: state <= ST_SOP;
        endcase
      end
    end
  end

endmodule

// File: doc/m_axis_cq_filter.md
# m_axis_cq_filter

Downstream stage of the completer-request (CQ) adapter on the Xilinx UltraScale PHY. It consumes the legacy-format request TLP stream (3/4-DW header in beat 0), forwards memory read/write requests, and silently drops all other request types (I/O, configuration, locked read). It provides a small packet-agnostic FIFO that decouples the adapter from depacketizer backpressure, and it reports how many TLPs were dropped.

## Interface
- DATA_WIDTH, 256, stream data width in bits.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- DEPTH, 4, FIFO entries; power of two, ≥2.

- user_clk  input  1  clock; all logic on rising edge.
- user_reset  input  1  reset, asynchronous, active-high.
- s_axis_tdata  input  DATA_WIDTH  legacy TLP data from the CQ adapter.
- s_axis_tkeep  input  KEEP_WIDTH  byte enables.
- s_axis_tlast  input  1  last beat of TLP.
- s_axis_tuser  input  85  sideband; carried through unmodified.
- s_axis_tvalid  input  1  beat valid.
- s_axis_tready  output  4  ready to adapter; all 4 bits identical.
- m_axis_tdata  output  DATA_WIDTH  filtered stream data.
- m_axis_tkeep  output  KEEP_WIDTH  byte enables.
- m_axis_tlast  output  1  last beat.
- m_axis_tuser  output  85  sideband.
- m_axis_tvalid  output  1  beat valid.
- m_axis_tready  input  1  downstream ready.
- drop_count  output  16  saturating count of dropped TLPs.
- drop_pulse  output  1  one-cycle pulse per dropped TLP.

## Operation
- Beat transfer on input: s_axis_tvalid & s_axis_tready[0]. On output: m_axis_tvalid & m_axis_tready.
- Classification uses beat 0 only: fmt = tdata[31:29], type = tdata[28:24]. Pass if type == 5'b00000 and fmt ∈ {3'b000, 3'b010, 3'b001, 3'b011}. Drop otherwise, including type 5'b00001 (locked read).
- FSM states:
  - SOP: the next input beat is beat 0. On transfer, pass → write beat to FIFO; tlast=0 → PASS, tlast=1 → stay SOP. On drop → discard beat, pulse drop; tlast=0 → DROP, tlast=1 → stay SOP.
  - PASS: every transferred beat is written to FIFO; tlast → SOP.
  - DROP: every transferred beat is discarded; tlast → SOP.
- drop_pulse and the drop_count increment occur on the beat-0 transfer of a dropped TLP, not at its tlast.
- s_axis_tready: {4{!full}} in SOP and PASS; 4'hF in DROP, independent of FIFO state.
- FIFO stores {tdata, tkeep, tlast, tuser} per entry. Read and write pointers are log2(DEPTH)+1 bits and wrap naturally. full = (occupancy == DEPTH). Output fields are driven from the head entry.
- drop_count saturates at 16'hFFFF and holds there. drop_pulse still fires after saturation.

## Timing
- Reset (async assert; release is synchronous to user_clk) sets: FSM = SOP, FIFO empty, m_axis_tvalid = 0, s_axis_tready = 4'hF, drop_count = 0, drop_pulse = 0. m_axis_tdata/tkeep/tuser/tlast are don't-care while tvalid = 0.
- Latency: a beat written at edge N appears with m_axis_tvalid = 1 after edge N (registered FIFO, 1-cycle minimum).
- s_axis_tready depends only on registered state (FSM, occupancy). There is no combinational path from m_axis_tready.
- When the FIFO is full, a push and a pop in the same cycle cannot occur: tready is low, so only the pop happens, and tready rises next cycle.
- When the FIFO is not full, a simultaneous push and pop leaves occupancy unchanged.
- m_axis_tvalid, once high, stays high with stable data until a transfer. Entries are never reordered or dropped after being written.
- drop_pulse is registered and is high for exactly the cycle after the beat-0 transfer.
- Reset asserted mid-packet discards the FIFO contents and partial TLP. After release, the next input beat is treated as beat 0.

## Test plan
- Single-beat MRd (tdata[31:24]=8'h00, tlast=1), m_axis_tready=1 → identical beat on output 1 cycle later; drop_count stays 0.
- 3-beat MWr (8'h40) with m_axis_tready=0 → 3 beats buffered, tready stays high, then drops after beat 4 of a following TLP fills DEPTH=4. Release tready → 4 beats out, in order, with tkeep/tuser intact.
- 2-beat CfgWr0 (8'h44) while FIFO is full → tready stays low until the FIFO is no longer full, beat 0 is accepted, then tready = 4'hF for beat 1. Nothing is written; drop_pulse fires once; drop_count = 1.
- Interleaved sequence MRd, IORd (8'h02), locked read (8'h01), MWr → only MRd and MWr are output; drop_count = 2.
- Preload drop_count near saturation via 65 537 dropped single-beat CfgRd → drop_count = 16'hFFFF, with drop_pulse on every TLP.
- Assert user_reset during beat 2 of a 4-beat MWr → m_axis_tvalid = 0 immediately. A post-reset MRd single beat passes correctly.
